ysyx_22040127_mem_stage: RTL and testbench

YSYX_22040127_MEM_STAGE -- requirements
Module: ysyx_22040127_mem_stage

---
 rtl/ysyx_22040127_mem_stage.sv | 201 ++++++++++++++++++++
 tb/tb_ysyx_22040127_mem_stage.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22040127_mem_stage.sv
// MEM pipeline stage: holds one instruction from EX, runs the data-memory
// handshake for loads/stores, aligns/extends load data and forms the WB bundle.
module ysyx_22040127_mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_to_mem_valid,
  output logic        mem_allowin,
  input  logic [31:0] ex_pc,
  input  logic [4:0]  ex_rd,
  input  logic        ex_reg_wen,
  input  logic [63:0] ex_alu_result,
  input  logic        ex_load,
  input  logic        ex_store,
  input  logic [1:0]  ex_size,
  input  logic        ex_unsigned,
  input  logic [63:0] ex_store_data,
  input  logic        mem_flush,
  output logic        dm_req,
  output logic        dm_wr,
  output logic [63:0] dm_addr,
  output logic [63:0] dm_wdata,
  output logic [7:0]  dm_wstrb,
  input  logic        dm_addr_ok,
  input  logic        dm_data_ok,
  input  logic [63:0] dm_rdata,
  input  logic        wb_allowin,
  output logic        mem_to_wb_valid,
  output logic [31:0] mem_to_wb_pc,
  output logic [4:0]  mem_to_wb_rd,
  output logic        mem_to_wb_reg_wen,
  output logic [63:0] mem_to_wb_wdata,
  output logic        mem_to_wb_memwrite,
  output logic [63:0] mem_to_wb_diff_addr,
  output logic [63:0] mem_to_wb_diff_data
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t      state;
  logic        mem_valid;
  logic        cancel;
  logic [31:0] pc_p1;
  logic [4:0]  rd_p1;
  logic        reg_wen_p1;
  logic [63:0] alu_p1;
  logic        load_p1;
  logic        store_p1;
  logic [1:0]  size_p1;
  logic        zext_p1;
  logic [63:0] sdata_p1;
  logic [63:0] rdata_p1;

  logic mem_op;
  logic mem_ready_go;
  logic accept;
  logic handoff;
  logic ex_mem_op;

  function automatic logic [63:0] align_addr(input logic [63:0] a, input logic [1:0] sz);
    case (sz)
      2'd0:    return a;
      2'd1:    return {a[63:1], 1'b0};
      2'd2:    return {a[63:2], 2'b00};
      default: return {a[63:3], 3'b000};
    endcase
  endfunction

  function automatic logic [7:0] byte_strobe(input logic [2:0] off, input logic [1:0] sz);
    case (sz)
      2'd0:    return 8'h01 << off;
      2'd1:    return 8'h03 << off;
      2'd2:    return 8'h0F << off;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic [63:0] replicate(input logic [63:0] d, input logic [1:0] sz);
    case (sz)
      2'd0:    return {8{d[7:0]}};
      2'd1:    return {4{d[15:0]}};
      2'd2:    return {2{d[31:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic signed [63:0] load_extend(input logic [63:0] raw, input logic [2:0] off,
                                                     input logic [1:0] sz, input logic zext);
    logic [63:0] sh;
    sh = raw >> {off, 3'b000};
    case (sz)
      2'd0:    return zext ? {56'd0, sh[7:0]}  : {{56{sh[7]}},  sh[7:0]};
      2'd1:    return zext ? {48'd0, sh[15:0]} : {{48{sh[15]}}, sh[15:0]};
      2'd2:    return zext ? {32'd0, sh[31:0]} : {{32{sh[31]}}, sh[31:0]};
      default: return raw;
    endcase
  endfunction

  assign mem_op       = load_p1 | store_p1;
  assign ex_mem_op    = ex_load | ex_store;
  assign mem_ready_go = !mem_op || (state == DONE);
  // A cancelled transfer still owes us a response; block new work until it lands.
  assign mem_allowin  = !cancel && (!mem_valid || (mem_ready_go && wb_allowin));
  assign accept       = ex_to_mem_valid && mem_allowin;
  assign handoff      = mem_valid && mem_ready_go && wb_allowin;

  assign dm_req   = (state == REQ);
  assign dm_wr    = store_p1;
  assign dm_addr  = align_addr(alu_p1, size_p1);
  assign dm_wdata = replicate(sdata_p1, size_p1);
  assign dm_wstrb = byte_strobe(dm_addr[2:0], size_p1);

  assign mem_to_wb_valid     = mem_valid && mem_ready_go && !mem_flush;
  assign mem_to_wb_pc        = pc_p1;
  assign mem_to_wb_rd        = rd_p1;
  assign mem_to_wb_reg_wen   = reg_wen_p1;
  assign mem_to_wb_wdata     = load_p1 ? load_extend(rdata_p1, dm_addr[2:0], size_p1, zext_p1) : alu_p1;
  assign mem_to_wb_memwrite  = store_p1;
  assign mem_to_wb_diff_addr = store_p1 ? dm_addr  : 64'd0;
  assign mem_to_wb_diff_data = store_p1 ? dm_wdata : 64'd0;

  // EX -> MEM boundary and memory handshake FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      mem_valid  <= 1'b0;
      cancel     <= 1'b0;
      pc_p1      <= 32'd0;
      rd_p1      <= 5'd0;
      reg_wen_p1 <= 1'b0;
      alu_p1     <= 64'd0;
      load_p1    <= 1'b0;
      store_p1   <= 1'b0;
      size_p1    <= 2'd0;
      zext_p1    <= 1'b0;
      sdata_p1   <= 64'd0;
      rdata_p1   <= 64'd0;
    end else begin
      if (accept) begin
        pc_p1      <= ex_pc;
        rd_p1      <= ex_rd;
        reg_wen_p1 <= ex_reg_wen;
        alu_p1     <= ex_alu_result;
        load_p1    <= ex_load;
        store_p1   <= ex_store;
        size_p1    <= ex_size;
        zext_p1    <= ex_unsigned;
        sdata_p1   <= ex_store_data;
      end

      if (accept)
        mem_valid <= 1'b1;
      else if (mem_flush || mem_allowin)
        mem_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (accept && ex_mem_op) state <= REQ;
        end
        REQ: begin
          if (mem_flush) begin
            // Accepted-but-unanswered request must still drain its response.
            if (dm_addr_ok && !dm_data_ok) begin
              state  <= WAIT;
              cancel <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end else if (dm_addr_ok) begin
            if (dm_data_ok) begin
              state    <= DONE;
              rdata_p1 <= dm_rdata;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (dm_data_ok) begin
            if (cancel || mem_flush) begin
              state  <= IDLE;
              cancel <= 1'b0;
            end else begin
              state    <= DONE;
              rdata_p1 <= dm_rdata;
            end
          end else if (mem_flush) begin
            cancel <= 1'b1;
          end
        end
        DONE: begin
          if (accept && ex_mem_op)
            state <= REQ;
          else if (mem_flush || handoff)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22040127_mem_stage.sv
// Bench for the MEM stage: directed handshake scenarios followed by randomized
// traffic compared against a transaction-level reference model.
module tb_ysyx_22040127_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_to_mem_valid;
  logic        mem_allowin;
  logic [31:0] ex_pc;
  logic [4:0]  ex_rd;
  logic        ex_reg_wen;
  logic [63:0] ex_alu_result;
  logic        ex_load;
  logic        ex_store;
  logic [1:0]  ex_size;
  logic        ex_unsigned;
  logic [63:0] ex_store_data;
  logic        mem_flush;
  logic        dm_req;
  logic        dm_wr;
  logic [63:0] dm_addr;
  logic [63:0] dm_wdata;
  logic [7:0]  dm_wstrb;
  logic        dm_addr_ok;
  logic        dm_data_ok;
  logic [63:0] dm_rdata;
  logic        wb_allowin;
  logic        mem_to_wb_valid;
  logic [31:0] mem_to_wb_pc;
  logic [4:0]  mem_to_wb_rd;
  logic        mem_to_wb_reg_wen;
  logic [63:0] mem_to_wb_wdata;
  logic        mem_to_wb_memwrite;
  logic [63:0] mem_to_wb_diff_addr;
  logic [63:0] mem_to_wb_diff_data;

  always #5 clk = ~clk;

  ysyx_22040127_mem_stage dut (
    .clk(clk), .rst(rst),
    .ex_to_mem_valid(ex_to_mem_valid), .mem_allowin(mem_allowin),
    .ex_pc(ex_pc), .ex_rd(ex_rd), .ex_reg_wen(ex_reg_wen),
    .ex_alu_result(ex_alu_result), .ex_load(ex_load), .ex_store(ex_store),
    .ex_size(ex_size), .ex_unsigned(ex_unsigned), .ex_store_data(ex_store_data),
    .mem_flush(mem_flush),
    .dm_req(dm_req), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_wstrb(dm_wstrb), .dm_addr_ok(dm_addr_ok), .dm_data_ok(dm_data_ok),
    .dm_rdata(dm_rdata), .wb_allowin(wb_allowin),
    .mem_to_wb_valid(mem_to_wb_valid), .mem_to_wb_pc(mem_to_wb_pc),
    .mem_to_wb_rd(mem_to_wb_rd), .mem_to_wb_reg_wen(mem_to_wb_reg_wen),
    .mem_to_wb_wdata(mem_to_wb_wdata), .mem_to_wb_memwrite(mem_to_wb_memwrite),
    .mem_to_wb_diff_addr(mem_to_wb_diff_addr), .mem_to_wb_diff_data(mem_to_wb_diff_data)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h expected=%h", tag, got, exp);
  endtask

  // Reference model: byte-level view of alignment, strobes, lanes and extension.
  function automatic logic [63:0] m_aligned(input logic [63:0] a, input logic [1:0] sz);
    logic [63:0] n;
    n = 64'd1 << sz;
    return a & ~(n - 64'd1);
  endfunction

  function automatic logic [7:0] m_strb(input logic [63:0] a, input logic [1:0] sz);
    logic [7:0] s;
    int n, off;
    s = 8'd0;
    n = 1 << sz;
    off = int'(m_aligned(a, sz) & 64'd7);
    for (int i = 0; i < n; i++) s[off + i] = 1'b1;
    return s;
  endfunction

  function automatic logic [63:0] m_wdata(input logic [63:0] d, input logic [1:0] sz);
    logic [63:0] w;
    int n;
    n = 1 << sz;
    for (int i = 0; i < 8; i++) w[8*i +: 8] = d[8*(i % n) +: 8];
    return w;
  endfunction

  function automatic logic [63:0] m_load(input logic [63:0] a, input logic [1:0] sz,
                                         input logic zx, input logic [63:0] r);
    logic [63:0] v;
    int n, off;
    n = 1 << sz;
    off = int'(m_aligned(a, sz) & 64'd7);
    v = 64'd0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = r[8*(off + i) +: 8];
    if (!zx && n < 8 && v[8*n - 1]) v = v | ~((64'd1 << (8*n)) - 64'd1);
    return v;
  endfunction

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        wen;
    logic [63:0] alu;
    int          kind;
    logic [1:0]  size;
    logic        zext;
    logic [63:0] sdata;
  } instr_t;

  function automatic instr_t rand_instr();
    instr_t t;
    t.kind  = int'($urandom_range(0, 2));
    t.pc    = $urandom;
    t.rd    = 5'($urandom);
    t.wen   = 1'($urandom);
    t.alu   = {$urandom, $urandom};
    t.size  = 2'($urandom);
    t.zext  = 1'($urandom);
    t.sdata = {$urandom, $urandom};
    return t;
  endfunction

  task automatic drive_ex(input instr_t t);
    ex_pc         = t.pc;
    ex_rd         = t.rd;
    ex_reg_wen    = t.wen;
    ex_alu_result = t.alu;
    ex_load       = (t.kind == 1);
    ex_store      = (t.kind == 2);
    ex_size       = t.size;
    ex_unsigned   = t.zext;
    ex_store_data = t.sdata;
  endtask

  task automatic idle_inputs();
    ex_to_mem_valid = 1'b0;
    ex_pc = 32'd0; ex_rd = 5'd0; ex_reg_wen = 1'b0; ex_alu_result = 64'd0;
    ex_load = 1'b0; ex_store = 1'b0; ex_size = 2'd0; ex_unsigned = 1'b0;
    ex_store_data = 64'd0; mem_flush = 1'b0;
    dm_addr_ok = 1'b0; dm_data_ok = 1'b0; dm_rdata = 64'd0; wb_allowin = 1'b1;
  endtask

  task automatic offer_load(input logic [63:0] addr, input logic [1:0] sz, input logic zx);
    ex_to_mem_valid = 1'b1;
    ex_pc = 32'h8000_0100; ex_rd = 5'd7; ex_reg_wen = 1'b1;
    ex_alu_result = addr; ex_load = 1'b1; ex_store = 1'b0;
    ex_size = sz; ex_unsigned = zx; ex_store_data = 64'd0;
  endtask

  task automatic dir_load(input string tag, input logic [63:0] addr, input logic [1:0] sz,
                          input logic zx, input logic [63:0] rdat, input logic [63:0] exp);
    @(negedge clk); offer_load(addr, sz, zx); wb_allowin = 1'b1;
    @(negedge clk); ex_to_mem_valid = 1'b0; dm_addr_ok = 1'b1;
    #1;
    chk({tag, "_req"}, 64'(dm_req), 64'd1);
    chk({tag, "_addr"}, dm_addr, m_aligned(addr, sz));
    chk({tag, "_wr"}, 64'(dm_wr), 64'd0);
    @(negedge clk); dm_addr_ok = 1'b0;
    #1 chk({tag, "_wait_req"}, 64'(dm_req), 64'd0);
    @(negedge clk); dm_data_ok = 1'b1; dm_rdata = rdat;
    @(negedge clk); dm_data_ok = 1'b0; dm_rdata = {$urandom, $urandom};
    #1;
    chk({tag, "_valid"}, 64'(mem_to_wb_valid), 64'd1);
    chk({tag, "_wdata"}, mem_to_wb_wdata, exp);
    @(negedge clk);
    #1 chk({tag, "_gone"}, 64'(mem_to_wb_valid), 64'd0);
  endtask

  // Random-phase model state
  instr_t      nxt, cur;
  bit          have_cur, done, req_acc, dok;
  int          delay, issued, retired;
  logic [63:0] got_rdata;
  bit          exp_rg, exp_req;

  task automatic rand_cycle(input int target);
    @(negedge clk);
    dm_addr_ok = 1'b0; dm_data_ok = 1'b0; dm_rdata = {$urandom, $urandom};
    dok = 1'b0;
    exp_req = have_cur && cur.kind != 0 && !req_acc;
    chk("dm_req", 64'(dm_req), 64'(exp_req));
    if (dm_req && exp_req) begin
      chk("dm_addr", dm_addr, m_aligned(cur.alu, cur.size));
      chk("dm_wr", 64'(dm_wr), 64'(cur.kind == 2));
      if (cur.kind == 2) begin
        chk("dm_wstrb", 64'(dm_wstrb), 64'(m_strb(cur.alu, cur.size)));
        chk("dm_wdata", dm_wdata, m_wdata(cur.sdata, cur.size));
      end
      if ($urandom_range(0, 2) != 0) begin
        dm_addr_ok = 1'b1; req_acc = 1'b1; delay = int'($urandom_range(0, 3));
      end
    end else if (req_acc && !done && delay > 0) begin
      delay--;
    end
    if (have_cur && req_acc && !done && delay == 0) begin
      got_rdata = {$urandom, $urandom};
      dm_rdata = got_rdata; dm_data_ok = 1'b1; dok = 1'b1;
    end
    wb_allowin = ($urandom_range(0, 3) != 0);
    if (issued < target) begin
      drive_ex(nxt);
      ex_to_mem_valid = ($urandom_range(0, 3) != 0);
    end else begin
      ex_to_mem_valid = 1'b0;
    end
    #1;
    exp_rg = have_cur && (cur.kind == 0 || done);
    chk("wb_valid", 64'(mem_to_wb_valid), 64'(exp_rg));
    chk("allowin", 64'(mem_allowin), 64'(!have_cur || (exp_rg && wb_allowin)));
    if (mem_to_wb_valid && exp_rg) begin
      chk("wb_pc", 64'(mem_to_wb_pc), 64'(cur.pc));
      chk("wb_rd", 64'(mem_to_wb_rd), 64'(cur.rd));
      chk("wb_wen", 64'(mem_to_wb_reg_wen), 64'(cur.wen));
      chk("wb_wdata", mem_to_wb_wdata,
          (cur.kind == 1) ? m_load(cur.alu, cur.size, cur.zext, got_rdata) : cur.alu);
      chk("wb_memwrite", 64'(mem_to_wb_memwrite), 64'(cur.kind == 2));
      chk("wb_diff_addr", mem_to_wb_diff_addr, (cur.kind == 2) ? m_aligned(cur.alu, cur.size) : 64'd0);
      chk("wb_diff_data", mem_to_wb_diff_data, (cur.kind == 2) ? m_wdata(cur.sdata, cur.size) : 64'd0);
    end
    if (exp_rg && wb_allowin) begin
      have_cur = 1'b0; retired++;
    end
    if (dok) done = 1'b1;
    if (ex_to_mem_valid && mem_allowin) begin
      cur = nxt; have_cur = 1'b1; done = 1'b0; req_acc = 1'b0; issued++;
      nxt = rand_instr();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    rst = 1'b1;
    ex_to_mem_valid = 1'b1; ex_load = 1'b1; ex_alu_result = 64'hDEAD_BEEF;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_allowin", 64'(mem_allowin), 64'd1);
    chk("rst_req", 64'(dm_req), 64'd0);
    chk("rst_valid", 64'(mem_to_wb_valid), 64'd0);
    chk("rst_wdata", mem_to_wb_wdata, 64'd0);
    chk("rst_memwrite", 64'(mem_to_wb_memwrite), 64'd0);
    chk("rst_diff_addr", mem_to_wb_diff_addr, 64'd0);
    @(negedge clk); idle_inputs(); rst = 1'b0;

    // ALU op
    @(negedge clk);
    ex_to_mem_valid = 1'b1; ex_pc = 32'h8000_0000; ex_rd = 5'd5; ex_reg_wen = 1'b1;
    ex_alu_result = 64'h1234;
    #1 chk("alu_allowin", 64'(mem_allowin), 64'd1);
    @(negedge clk); ex_to_mem_valid = 1'b0;
    #1;
    chk("alu_valid", 64'(mem_to_wb_valid), 64'd1);
    chk("alu_wdata", mem_to_wb_wdata, 64'h1234);
    chk("alu_pc", 64'(mem_to_wb_pc), 64'h8000_0000);
    chk("alu_rd", 64'(mem_to_wb_rd), 64'd5);
    chk("alu_noreq", 64'(dm_req), 64'd0);
    @(negedge clk);
    #1 chk("alu_gone", 64'(mem_to_wb_valid), 64'd0);

    dir_load("lb", 64'h8000_1003, 2'd0, 1'b0, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FF80);
    dir_load("lbu", 64'h8000_1003, 2'd0, 1'b1, 64'h0000_0000_8000_0000, 64'h80);
    dir_load("lh_mis", 64'h8000_1007, 2'd1, 1'b0, 64'h1234_5678_9ABC_DEF0, 64'h0000_0000_0000_1234);

    // SH with addr_ok and data_ok together
    @(negedge clk);
    ex_to_mem_valid = 1'b1; ex_load = 1'b0; ex_store = 1'b1; ex_size = 2'd1;
    ex_alu_result = 64'h8000_1006; ex_store_data = 64'h1111_2222_3333_ABCD;
    @(negedge clk); ex_to_mem_valid = 1'b0; dm_addr_ok = 1'b1; dm_data_ok = 1'b1;
    #1;
    chk("sh_req", 64'(dm_req), 64'd1);
    chk("sh_wr", 64'(dm_wr), 64'd1);
    chk("sh_wstrb", 64'(dm_wstrb), 64'hC0);
    chk("sh_wdata", dm_wdata, 64'hABCD_ABCD_ABCD_ABCD);
    @(negedge clk); dm_addr_ok = 1'b0; dm_data_ok = 1'b0;
    #1;
    chk("sh_valid", 64'(mem_to_wb_valid), 64'd1);
    chk("sh_memwrite", 64'(mem_to_wb_memwrite), 64'd1);
    chk("sh_diff_addr", mem_to_wb_diff_addr, 64'h8000_1006);
    chk("sh_diff_data", mem_to_wb_diff_data, 64'hABCD_ABCD_ABCD_ABCD);
    @(negedge clk); ex_store = 1'b0;

    // Flush while waiting for read data
    @(negedge clk); offer_load(64'h8000_2000, 2'd3, 1'b0);
    @(negedge clk); ex_to_mem_valid = 1'b0; dm_addr_ok = 1'b1;
    @(negedge clk); dm_addr_ok = 1'b0; mem_flush = 1'b1;
    #1;
    chk("fw_valid", 64'(mem_to_wb_valid), 64'd0);
    chk("fw_allowin0", 64'(mem_allowin), 64'd0);
    @(negedge clk); mem_flush = 1'b0;
    ex_to_mem_valid = 1'b1; ex_load = 1'b0; ex_alu_result = 64'h5555; ex_pc = 32'h8000_0200;
    #1 chk("fw_allowin1", 64'(mem_allowin), 64'd0);
    @(negedge clk);
    #1 chk("fw_allowin2", 64'(mem_allowin), 64'd0);
    @(negedge clk); dm_data_ok = 1'b1; dm_rdata = 64'hFFFF_0000_FFFF_0000;
    #1;
    chk("fw_allowin3", 64'(mem_allowin), 64'd0);
    chk("fw_valid3", 64'(mem_to_wb_valid), 64'd0);
    @(negedge clk); dm_data_ok = 1'b0;
    #1;
    chk("fw_allowin4", 64'(mem_allowin), 64'd1);
    chk("fw_valid4", 64'(mem_to_wb_valid), 64'd0);
    @(negedge clk); ex_to_mem_valid = 1'b0;
    #1;
    chk("fw_next_valid", 64'(mem_to_wb_valid), 64'd1);
    chk("fw_next_wdata", mem_to_wb_wdata, 64'h5555);

    // Flush before the request is accepted
    @(negedge clk); offer_load(64'h8000_2008, 2'd2, 1'b0);
    @(negedge clk); ex_to_mem_valid = 1'b0; mem_flush = 1'b1;
    #1 chk("fr_req", 64'(dm_req), 64'd1);
    @(negedge clk); mem_flush = 1'b0;
    #1;
    chk("fr_withdrawn", 64'(dm_req), 64'd0);
    chk("fr_allowin", 64'(mem_allowin), 64'd1);

    // Stall in DONE
    @(negedge clk); offer_load(64'h8000_3004, 2'd2, 1'b0); wb_allowin = 1'b0;
    @(negedge clk); ex_to_mem_valid = 1'b0; dm_addr_ok = 1'b1; dm_data_ok = 1'b1;
    dm_rdata = 64'h8765_4321_0000_0000;
    @(negedge clk); dm_addr_ok = 1'b0; dm_data_ok = 1'b0; dm_rdata = 64'h0123_4567_89AB_CDEF;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("st_valid", 64'(mem_to_wb_valid), 64'd1);
      chk("st_wdata", mem_to_wb_wdata, 64'hFFFF_FFFF_8765_4321);
      chk("st_allowin", 64'(mem_allowin), 64'd0);
      chk("st_noreq", 64'(dm_req), 64'd0);
      @(negedge clk);
    end
    wb_allowin = 1'b1;
    #1 chk("st_release", 64'(mem_allowin), 64'd1);
    @(negedge clk);
    #1 chk("st_gone", 64'(mem_to_wb_valid), 64'd0);

    // Reset during REQ, then a stray response
    @(negedge clk); offer_load(64'h8000_4000, 2'd3, 1'b0);
    @(negedge clk); ex_to_mem_valid = 1'b0;
    #1 chk("rr_req", 64'(dm_req), 64'd1);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    #1;
    chk("rr_req_off", 64'(dm_req), 64'd0);
    chk("rr_allowin", 64'(mem_allowin), 64'd1);
    chk("rr_valid", 64'(mem_to_wb_valid), 64'd0);
    @(negedge clk); dm_data_ok = 1'b1; dm_rdata = 64'hAAAA_AAAA_AAAA_AAAA;
    @(negedge clk); dm_data_ok = 1'b0;
    #1;
    chk("rr_late_valid", 64'(mem_to_wb_valid), 64'd0);
    chk("rr_late_req", 64'(dm_req), 64'd0);
    chk("rr_late_allowin", 64'(mem_allowin), 64'd1);
    idle_inputs();

    // Randomized traffic
    have_cur = 1'b0; done = 1'b0; req_acc = 1'b0; delay = 0;
    issued = 0; retired = 0; got_rdata = 64'd0;
    nxt = rand_instr();
    for (int c = 0; c < 3000 && issued < 400; c++) rand_cycle(400);
    for (int c = 0; c < 200 && have_cur; c++) rand_cycle(0);
    chk("drained", 64'(have_cur), 64'd0);
    chk("retired", 64'(retired), 64'(issued));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
